// File: rtl/spi_cmd_decoder.sv
// Parses SPI command frames (opcode, address, data) into a small register bank.
// Register 0 drives the LEDs, read data goes out on tx_data, and rejected frames are counted.
module spi_cmd_decoder #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int LED_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic [7:0]       tx_data,
  output logic [LED_W-1:0] leds,
  output logic             wr_strobe,
  output logic [7:0]       err_cnt
);

  // state    | meaning
  // IDLE     | no frame open, bytes ignored
  // OPCODE   | waiting for the opcode byte
  // ADDR     | waiting for the start address byte
  // WDATA    | each byte writes reg[addr], addr auto-increments
  // RDATA    | each dummy byte advances addr, tx_data shows reg[addr]
  // DISCARD  | rest of the frame is ignored
  typedef enum logic [2:0] {
    S_IDLE, S_OPCODE, S_ADDR, S_WDATA, S_RDATA, S_DISCARD
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          regs_q [NUM_REGS];
  logic [7:0]          regs_d [NUM_REGS];
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_op_q, rd_op_d;
  logic [7:0]          tx_q, tx_d;
  logic                wr_q, wr_d;
  logic [7:0]          err_q, err_d;
  logic                rx_ok;
  logic [7:0]          err_inc;

  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  // A byte arriving together with frame_start belongs to no frame.
  assign rx_ok   = rx_valid && !frame_start;

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    addr_d  = addr_q;
    rd_op_d = rd_op_q;
    err_d   = err_q;
    wr_d    = 1'b0;

    if (rx_ok) begin
      case (state_q)
        S_OPCODE: begin
          case (rx_data)
            8'h01: begin
              state_d = S_ADDR;
              rd_op_d = 1'b0;
            end
            8'h02: begin
              state_d = S_ADDR;
              rd_op_d = 1'b1;
            end
            8'hCC: begin
              regs_d[0][0] = 1'b1;
              wr_d         = 1'b1;
              state_d      = S_DISCARD;
            end
            8'hDD: begin
              regs_d[0][0] = 1'b0;
              wr_d         = 1'b1;
              state_d      = S_DISCARD;
            end
            default: begin
              err_d   = err_inc;
              state_d = S_DISCARD;
            end
          endcase
        end
        S_ADDR: begin
          if ((32'(rx_data) >> ADDR_W) != 32'd0) begin
            err_d   = err_inc;
            state_d = S_DISCARD;
          end else begin
            addr_d  = rx_data[ADDR_W-1:0];
            state_d = rd_op_q ? S_RDATA : S_WDATA;
          end
        end
        S_WDATA: begin
          regs_d[addr_q] = rx_data;
          wr_d           = 1'b1;
          addr_d         = addr_q + ADDR_W'(1);
        end
        S_RDATA: begin
          addr_d = addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end

    if (frame_end)   state_d = S_IDLE;
    if (frame_start) state_d = S_OPCODE;

    // Reads never modify the bank, so the current bank is the data to present.
    tx_d = (state_d == S_RDATA) ? regs_q[addr_d] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      regs_q  <= '{default: '0};
      addr_q  <= '0;
      rd_op_q <= 1'b0;
      tx_q    <= 8'h00;
      wr_q    <= 1'b0;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      addr_q  <= addr_d;
      rd_op_q <= rd_op_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign tx_data   = tx_q;
  assign leds      = regs_q[0][LED_W-1:0];
  assign wr_strobe = wr_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed frames, random frames and an error flood,
// checked against a frame-level reference model.
module tb_spi_cmd_decoder;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       frame_end;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic [4:0] leds;
  logic       wr_strobe;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [7:0] mreg [8];
  int         merr;
  logic [7:0] fq [$];

  spi_cmd_decoder #(.NUM_REGS(8), .ADDR_W(3), .LED_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_data    (tx_data),
    .leds       (leds),
    .wr_strobe  (wr_strobe),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe === 1'b1) wr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    tick();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    merr = 0;
  endtask

  // Plays fq as one frame and checks tx_data per byte plus leds/err_cnt/strobe count at the end.
  task automatic run_frame(input bit do_end);
    int         mode;
    int         a;
    int         exp_wr;
    int         wr0;
    logic [7:0] b;
    logic [7:0] etx;
    mode   = 0;
    a      = 0;
    exp_wr = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("tx_after_start", tx_data, 8'h00);
    wr0 = wr_cnt;
    for (int k = 0; k < fq.size(); k++) begin
      b   = fq[k];
      etx = 8'h00;
      if (k == 0) begin
        if (b == 8'h01) mode = 1;
        else if (b == 8'h02) mode = 2;
        else if (b == 8'hCC) begin mreg[0][0] = 1'b1; exp_wr++; end
        else if (b == 8'hDD) begin mreg[0][0] = 1'b0; exp_wr++; end
        else if (merr < 255) merr++;
      end else if (k == 1 && mode != 0) begin
        if (b >= 8) begin
          if (merr < 255) merr++;
          mode = 0;
        end else begin
          a = int'(b);
          if (mode == 2) etx = mreg[a];
        end
      end else if (mode == 1) begin
        mreg[(a + k - 2) % 8] = b;
        exp_wr++;
      end else if (mode == 2) begin
        etx = mreg[(a + k - 1) % 8];
      end
      send_byte(b);
      chk("tx_byte", tx_data, etx);
    end
    if (do_end) begin
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      tick();
      chk("tx_after_end", tx_data, 8'h00);
    end
    chk("leds", leds, mreg[0][4:0]);
    chk("err_cnt", err_cnt, merr);
    chk("wr_strobe_count", wr_cnt - wr0, exp_wr);
  endtask

  task automatic read_all();
    fq = '{8'h02, 8'h00};
    for (int i = 0; i < 9; i++) fq.push_back(8'(i * 37));
    run_frame(1'b1);
  endtask

  initial begin
    int         kind;
    int         n;
    logic [7:0] v;

    rst_n = 1'b0;
    frame_start = 1'b0;
    frame_end = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    model_reset();
    tick();
    tick();
    chk("rst_tx", tx_data, 8'h00);
    chk("rst_leds", leds, 5'h00);
    chk("rst_wr", wr_strobe, 1'b0);
    chk("rst_err", err_cnt, 8'h00);
    rst_n = 1'b1;
    tick();

    fq = '{8'h01, 8'h02, 8'hAA, 8'hBB};                 run_frame(1'b1);
    fq = '{8'h02, 8'h02, 8'h00, 8'h00};                 run_frame(1'b1);
    fq = '{8'hCC};                                      run_frame(1'b1);
    fq = '{8'hDD};                                      run_frame(1'b1);
    fq = '{8'h01, 8'h00, 8'h1F};                        run_frame(1'b1);
    fq = '{8'h7E, 8'h01, 8'h55};                        run_frame(1'b1);
    fq = '{8'h01, 8'h09, 8'h55};                        run_frame(1'b1);
    fq = '{8'h01, 8'h07, 8'h11, 8'h22};                 run_frame(1'b1);
    fq = '{8'h01, 8'h04};                               run_frame(1'b0);
    fq = '{8'h02, 8'h04, 8'h00};                        run_frame(1'b1);
    read_all();

    // Reset in the middle of a write burst clears bank and outputs at once.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h77);
    rst_n = 1'b0;
    #2;
    chk("midrst_tx", tx_data, 8'h00);
    chk("midrst_leds", leds, 5'h00);
    chk("midrst_err", err_cnt, 8'h00);
    chk("midrst_wr", wr_strobe, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
    read_all();

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 5);
      fq.delete();
      case (kind)
        0, 1: begin
          fq.push_back(8'h01);
          fq.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7)));
          n = $urandom_range(1, 10);
          for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
        end
        2: begin
          fq.push_back(8'h02);
          fq.push_back(8'($urandom_range(0, 7)));
          n = $urandom_range(0, 9);
          for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
        end
        3: begin
          fq.push_back($urandom_range(0, 1) ? 8'hCC : 8'hDD);
          if ($urandom_range(0, 1) == 1) fq.push_back(8'h01);
        end
        default: begin
          v = 8'($urandom);
          if (v == 8'h01 || v == 8'h02 || v == 8'hCC || v == 8'hDD) v = 8'h7E;
          fq.push_back(v);
          fq.push_back(8'($urandom));
        end
      endcase
      run_frame($urandom_range(0, 4) != 0);
      if (f % 15 == 14) read_all();
    end
    read_all();

    for (int f = 0; f < 300; f++) begin
      fq = '{8'h7E};
      run_frame(1'b1);
    end
    chk("err_saturated", err_cnt, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
